// File: rtl/fft_twiddle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_twiddle_sequencer
// Purpose  : Walks every stage and butterfly of an iterative radix-2 DIT FFT,
//            drives the twiddle ROM read address and captures the ROM word
//            into a registered valid/ready stream, one beat per butterfly.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N           FFT length (power of two, >= 4); S = log2(N) stages
//   word_size   width of one twiddle component; ROM word is {re, im}
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       begin one full pass (sampled only while idle)
//   busy        high while a pass is running or draining its last beat
//   done        one-cycle pulse after the final beat is accepted
//   rom_addr    twiddle ROM read address (ROM is combinational)
//   rom_data    ROM word at rom_addr
//   out_valid   output beat valid
//   out_ready   consumer accepts the current beat
//   out_twiddle captured ROM word
//   out_stage   stage index s of the beat
//   out_bfly    butterfly index b of the beat
//   out_last    final beat of the pass
// ============================================================================
module fft_twiddle_sequencer #(
  parameter int N         = 32,
  parameter int word_size = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(N)-1:0]            rom_addr,
  input  logic [2*word_size-1:0]          rom_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*word_size-1:0]          out_twiddle,
  output logic [$clog2($clog2(N)):0]      out_stage,
  output logic [$clog2(N)-2:0]            out_bfly,
  output logic                            out_last
);

  localparam int c_stages = $clog2(N);
  localparam int c_aw     = $clog2(N);
  localparam int c_sw     = $clog2(c_stages) + 1;
  localparam int c_bw     = c_aw - 1;
  localparam int c_dw     = 2 * word_size;

  localparam logic [c_sw-1:0] c_s_last = c_sw'(c_stages - 1);
  localparam logic [c_bw-1:0] c_b_last = c_bw'(N / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic [c_sw-1:0]   s_q,       s_d;
  logic [c_bw-1:0]   b_q,       b_d;
  logic              valid_q,   valid_d;
  logic [c_dw-1:0]   twiddle_q, twiddle_d;
  logic [c_sw-1:0]   stage_q,   stage_d;
  logic [c_bw-1:0]   bfly_q,    bfly_d;
  logic              last_q,    last_d;
  logic              done_q,    done_d;

  logic              w_load;
  logic              w_is_last;
  logic [c_aw-1:0]   w_b_ext;
  logic [c_aw-1:0]   w_mask;
  logic [c_sw-1:0]   w_shamt;
  logic [c_aw-1:0]   w_addr;

  // --------------------------------------------------------------------------
  // Twiddle index for butterfly b of stage s: keep the low s bits of b and
  // scale them up to the full-length ROM, k = (b mod 2^s) << (S-1-s).
  // Built purely from the counter registers, so rom_addr never depends on
  // out_ready or any other input.
  // --------------------------------------------------------------------------
  always_comb begin
    w_b_ext = c_aw'(b_q);
    w_mask  = (c_aw'(1) << s_q) - c_aw'(1);
    w_shamt = c_s_last - s_q;
    w_addr  = (w_b_ext & w_mask) << w_shamt;
  end

  assign w_is_last = (s_q == c_s_last) && (b_q == c_b_last);

  // --------------------------------------------------------------------------
  // Next-state and output-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    b_d       = b_q;
    valid_d   = valid_q;
    twiddle_d = twiddle_q;
    stage_d   = stage_q;
    bfly_d    = bfly_q;
    last_d    = last_q;
    done_d    = 1'b0;
    w_load    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          s_d     = '0;
          b_d     = '0;
        end
      end

      ST_RUN: begin
        // The output slot can take a new beat when it is empty or the
        // current beat leaves this cycle; otherwise everything, including
        // the counters and hence rom_addr, is frozen.
        w_load = !valid_q || out_ready;
        if (w_load) begin
          twiddle_d = rom_data;
          stage_d   = s_q;
          bfly_d    = b_q;
          last_d    = w_is_last;
          valid_d   = 1'b1;
          if (w_is_last) begin
            state_d = ST_DRAIN;
          end else if (b_q == c_b_last) begin
            b_d = '0;
            s_d = s_q + 1'b1;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        // Only the final beat sits in the output slot here; once it is
        // taken the pass is complete.
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = last_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      twiddle_q <= '0;
      stage_q   <= '0;
      bfly_q    <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
      twiddle_q <= twiddle_d;
      stage_q   <= stage_d;
      bfly_q    <= bfly_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = done_q;
  assign rom_addr    = (state_q == ST_RUN) ? w_addr : '0;
  assign out_valid   = valid_q;
  assign out_twiddle = twiddle_q;
  assign out_stage   = stage_q;
  assign out_bfly    = bfly_q;
  assign out_last    = last_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_twiddle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_twiddle_sequencer
// Purpose  : Directed self-checking bench for fft_twiddle_sequencer. Drives an
//            N = 8 instance through plain, back-pressured, restarted and
//            reset-aborted passes, and an N = 32 instance under random
//            out_ready against a twiddle-index scoreboard and ROM image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_twiddle_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // N = 8 instance
  logic        start8 = 1'b0;
  logic        ready8 = 1'b1;
  logic        busy8, done8, valid8, last8;
  logic [2:0]  addr8;
  logic [31:0] rom8, tw8;
  logic [2:0]  stage8;
  logic [1:0]  bfly8;

  // N = 32 instance
  logic        start32 = 1'b0;
  logic        ready32 = 1'b1;
  logic        busy32, done32, valid32, last32;
  logic [4:0]  addr32;
  logic [31:0] rom32, tw32;
  logic [3:0]  stage32;
  logic [3:0]  bfly32;

  int n_cmp = 0;
  int n_err = 0;

  // Hand-derived N = 8 twiddle index per beat
  int k8 [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  function automatic logic [31:0] rom_word(input int a);
    return {16'(32'h4000 + a * 291), 16'(32'hC000 - a * 87)};
  endfunction

  assign rom8  = rom_word(int'(addr8));
  assign rom32 = rom_word(int'(addr32));

  fft_twiddle_sequencer #(.N(8), .word_size(16)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
    .rom_addr(addr8), .rom_data(rom8), .out_valid(valid8), .out_ready(ready8),
    .out_twiddle(tw8), .out_stage(stage8), .out_bfly(bfly8), .out_last(last8)
  );

  fft_twiddle_sequencer #(.N(32), .word_size(16)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .busy(busy32), .done(done32),
    .rom_addr(addr32), .rom_data(rom32), .out_valid(valid32), .out_ready(ready32),
    .out_twiddle(tw32), .out_stage(stage32), .out_bfly(bfly32), .out_last(last32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One N = 8 pass. Cycle 0 is the start cycle; the loop begins in cycle 1.
  // stall_at/stall_len hold out_ready low while that beat is presented.
  task automatic pass8(input bit pre_started, input int stall_at, input int stall_len,
                       input bit extra_starts, input bit chain);
    int exp_done, last_cyc, acc, ld, stall_cnt;
    bit v, rdy, accept;
    exp_done  = 14 + stall_len;
    last_cyc  = chain ? exp_done : exp_done + 1;
    acc = 0; ld = 0; v = 1'b0; stall_cnt = 0;
    if (!pre_started) begin
      start8 = 1'b1;
      tick();
    end
    start8 = 1'b0;
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      rdy = 1'b1;
      if (v && acc == stall_at && stall_cnt < stall_len) begin
        rdy = 1'b0;
        stall_cnt++;
      end
      ready8 = rdy;
      start8 = (extra_starts && (cyc == 3 || cyc == 7)) || (chain && cyc == exp_done);
      check($sformatf("p8 c%0d busy", cyc), busy8, cyc < exp_done);
      check($sformatf("p8 c%0d done", cyc), done8, cyc == exp_done);
      check($sformatf("p8 c%0d valid", cyc), valid8, v);
      if (v) begin
        check($sformatf("p8 c%0d twiddle", cyc), tw8, rom_word(k8[acc]));
        check($sformatf("p8 c%0d stage", cyc), stage8, acc / 4);
        check($sformatf("p8 c%0d bfly", cyc), bfly8, acc % 4);
        check($sformatf("p8 c%0d last", cyc), last8, acc == 11);
      end
      check($sformatf("p8 c%0d rom_addr", cyc), addr8,
            (cyc < exp_done && ld < 12) ? k8[ld] : 0);
      accept = v && rdy;
      if (accept) acc++;
      if (ld < 12 && (!v || rdy)) begin
        v = 1'b1;
        ld++;
      end else if (accept) begin
        v = 1'b0;
      end
      if (cyc < last_cyc) tick();
    end
    check("p8 beats", acc, 12);
    if (chain) tick();
    start8 = 1'b0;
    ready8 = 1'b1;
  endtask

  // One N = 32 pass under random out_ready.
  task automatic pass32();
    int acc, ld, ndone, tail, s, b, k;
    bit v, rdy, accept, done_exp;
    acc = 0; ld = 0; ndone = 0; tail = 0;
    v = 1'b0; done_exp = 1'b0;
    start32 = 1'b1;
    tick();
    start32 = 1'b0;
    for (int cyc = 1; cyc < 700 && tail < 3; cyc++) begin
      rdy = 1'($urandom_range(0, 1));
      ready32 = rdy;
      check($sformatf("p32 c%0d done", cyc), done32, done_exp);
      check($sformatf("p32 c%0d busy", cyc), busy32, acc < 80);
      check($sformatf("p32 c%0d valid", cyc), valid32, v);
      if (done32) ndone++;
      if (v) begin
        s = acc / 16;
        b = acc % 16;
        k = (b % (1 << s)) * (1 << (4 - s));
        check($sformatf("p32 c%0d twiddle", cyc), tw32, rom_word(k));
        check($sformatf("p32 c%0d stage", cyc), stage32, s);
        check($sformatf("p32 c%0d bfly", cyc), bfly32, b);
        check($sformatf("p32 c%0d last", cyc), last32, acc == 79);
      end
      if (acc < 80 && ld < 80) begin
        s = ld / 16;
        b = ld % 16;
        k = (b % (1 << s)) * (1 << (4 - s));
      end else begin
        k = 0;
      end
      check($sformatf("p32 c%0d rom_addr", cyc), addr32, k);
      accept   = v && rdy;
      done_exp = accept && acc == 79;
      if (accept) acc++;
      if (ld < 80 && (!v || rdy)) begin
        v = 1'b1;
        ld++;
      end else if (accept) begin
        v = 1'b0;
      end
      if (acc == 80) tail++;
      tick();
    end
    check("p32 beats", acc, 80);
    check("p32 done pulses", ndone, 1);
    ready32 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check("rst busy8", busy8, 0);
    check("rst done8", done8, 0);
    check("rst valid8", valid8, 0);
    check("rst last8", last8, 0);
    check("rst addr8", addr8, 0);
    check("rst tw8", tw8, 0);
    check("rst stage8", stage8, 0);
    check("rst bfly8", bfly8, 0);
    check("rst busy32", busy32, 0);
    check("rst valid32", valid32, 0);
    check("rst addr32", addr32, 0);
    rst = 1'b0;
    tick();

    pass8(1'b0, -1, 0, 1'b0, 1'b0);   // plain pass, ready high
    pass8(1'b0, 4, 3, 1'b0, 1'b0);    // 3-cycle stall on beat 5
    pass8(1'b0, 11, 4, 1'b0, 1'b0);   // 4-cycle hold on the last beat
    pass8(1'b0, -1, 0, 1'b1, 1'b1);   // stray starts, restart in done cycle
    pass8(1'b1, -1, 0, 1'b0, 1'b0);   // the restarted pass

    // Reset mid-pass, asserted in cycle 6
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("abort valid8", valid8, 0);
    check("abort busy8", busy8, 0);
    check("abort addr8", addr8, 0);
    check("abort done8", done8, 0);
    check("abort last8", last8, 0);
    check("abort tw8", tw8, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("abort idle%0d done8", i), done8, 0);
      check($sformatf("abort idle%0d busy8", i), busy8, 0);
    end
    pass8(1'b0, -1, 0, 1'b0, 1'b0);   // full pass after the abort

    pass32();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
